// File: rtl/wb_btn_debounce.sv
// Wishbone B4 classic button debouncer: sync, tick-based debounce, W1C press flags, level IRQ.
// Optional release-edge flags at 0x14 when WB_BTN_RELEASE_EDGE_EN is defined.
module wb_btn_debounce #(
    parameter int          NUM_BTN    = 5,
    parameter logic [19:0] DB_DIV_RST = 20'd49999,
    parameter int          DB_STABLE  = 3
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic               irq_o
);

    localparam logic [3:0] STABLE_LAST = 4'(DB_STABLE - 1);

    logic [NUM_BTN-1:0]      r_sync1, r_sync2, r_state, r_edge, r_irq_en;
    logic [NUM_BTN-1:0][3:0] r_cnt;
    logic [19:0]             r_div, r_tick_cnt;

    logic                    w_req, w_wr, w_tick, w_pend;
    logic                    w_wr_edge, w_wr_ien, w_wr_div;
    logic [31:0]             w_mask, w_wbits, w_rdata;
    logic [19:0]             w_div_nxt;
    logic [NUM_BTN-1:0]      w_state_nxt, w_rise, w_edge_clr;
    logic [NUM_BTN-1:0][3:0] w_cnt_nxt;
    logic                    w_unused;

    assign wb_err_o   = 1'b0;
    assign wb_rty_o   = 1'b0;
    assign w_req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign w_wr       = w_req & wb_we_i;
    assign w_mask     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_wbits    = wb_dat_i & w_mask;
    assign w_wr_edge  = w_wr && (wb_adr_i[5:2] == 4'h2);
    assign w_wr_ien   = w_wr && (wb_adr_i[5:2] == 4'h3);
    assign w_wr_div   = w_wr && (wb_adr_i[5:2] == 4'h4);
    assign w_div_nxt  = (r_div & ~w_mask[19:0]) | w_wbits[19:0];
    assign w_tick     = (r_tick_cnt == 20'd0);
    assign w_edge_clr = w_wr_edge ? w_wbits[NUM_BTN-1:0] : {NUM_BTN{1'b0}};
    assign w_rise     = w_state_nxt & ~r_state;
    assign w_unused   = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i, w_mask, w_wbits};

    // A bit flips only after DB_STABLE consecutive ticks that disagree with the debounced state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (w_tick) begin
                if (r_sync2[i] != r_state[i]) begin
                    if (r_cnt[i] == STABLE_LAST) begin
                        w_state_nxt[i] = r_sync2[i];
                        w_cnt_nxt[i]   = 4'd0;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] + 4'd1;
                    end
                end else begin
                    w_cnt_nxt[i] = 4'd0;
                end
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

`ifdef WB_BTN_RELEASE_EDGE_EN
    logic [NUM_BTN-1:0] r_rel, w_fall, w_rel_clr;
    assign w_fall    = ~w_state_nxt & r_state;
    assign w_rel_clr = (w_wr && (wb_adr_i[5:2] == 4'h5)) ? w_wbits[NUM_BTN-1:0] : {NUM_BTN{1'b0}};
    assign w_pend    = |((r_edge | r_rel) & r_irq_en);

    // Release flags: set on debounced 1->0, W1C, set beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rel <= {NUM_BTN{1'b0}};
        end else begin
            r_rel <= (r_rel & ~w_rel_clr) | w_fall;
        end
    end
`else
    assign w_pend = |(r_edge & r_irq_en);
`endif

    // Register read mux; unmapped offsets read zero.
    always_comb begin
        w_rdata = 32'd0;
        case (wb_adr_i[5:2])
            4'h0:    w_rdata = 32'(r_sync2);
            4'h1:    w_rdata = 32'(r_state);
            4'h2:    w_rdata = 32'(r_edge);
            4'h3:    w_rdata = 32'(r_irq_en);
            4'h4:    w_rdata = {12'd0, r_div};
`ifdef WB_BTN_RELEASE_EDGE_EN
            4'h5:    w_rdata = 32'(r_rel);
`endif
            default: w_rdata = 32'd0;
        endcase
    end

    // Input synchronizer and debounce state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sync1 <= {NUM_BTN{1'b0}};
            r_sync2 <= {NUM_BTN{1'b0}};
            r_state <= {NUM_BTN{1'b0}};
            r_cnt   <= {NUM_BTN{4'd0}};
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Tick divider; a DIV write restarts the period with the new value.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tick_cnt <= 20'd0;
        end else if (w_wr_div) begin
            r_tick_cnt <= w_div_nxt;
        end else if (w_tick) begin
            r_tick_cnt <= r_div;
        end else begin
            r_tick_cnt <= r_tick_cnt - 20'd1;
        end
    end

    // Bus handshake: one ack per request, read data captured alongside it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack_o <= w_req;
            if (w_req) begin
                wb_dat_o <= w_rdata;
            end
        end
    end

    // Control registers, press flags (set beats a same-cycle clear) and the interrupt.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_irq_en <= {NUM_BTN{1'b0}};
            r_div    <= DB_DIV_RST;
            r_edge   <= {NUM_BTN{1'b0}};
            irq_o    <= 1'b0;
        end else begin
            if (w_wr_ien) begin
                r_irq_en <= (r_irq_en & ~w_mask[NUM_BTN-1:0]) | w_wbits[NUM_BTN-1:0];
            end
            if (w_wr_div) begin
                r_div <= w_div_nxt;
            end
            r_edge <= (r_edge & ~w_edge_clr) | w_rise;
            irq_o  <= w_pend;
        end
    end

endmodule
